// File: rtl/hack_exec_controller.sv
// Run-control sequencer for the Hack CPU: boot hold, run/halt/step, PC breakpoint
// and a saturating executed-cycle counter.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   BOOT  | cpu_rst held high while the boot counter drains
//   HALT  | CPU frozen, waiting for step/run
//   RUN   | CPU enabled unless the armed breakpoint matches pc
//   STEP  | CPU enabled for exactly one cycle, then HALT
module hack_exec_controller #(
   parameter int BOOT_CYCLES  = 4,
   parameter bit START_HALTED = 1'b0,
   parameter int CYC_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             soft_rst_req,
   input  logic             bp_en,
   input  logic [14:0]      bp_addr,
   input  logic [14:0]      pc,
   output logic             cpu_rst,
   output logic             cpu_en,
   output logic             halted,
   output logic             bp_hit,
   output logic [1:0]       state,
   output logic [CYC_W-1:0] cycle_count
);

   localparam int BC_W = (BOOT_CYCLES > 2) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BC_W-1:0] BOOT_LOAD = BC_W'(BOOT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_HALT = 2'd1,
      ST_RUN  = 2'd2,
      ST_STEP = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [BC_W-1:0]  boot_cnt_q, boot_cnt_d;
   logic             bp_hit_q, bp_hit_d;
   logic             bp_armed_q, bp_armed_d;
   logic             cpu_rst_q, cpu_rst_d;
   logic             halted_q, halted_d;
   logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
   logic             bp_match;

   // Enable is combinational so the instruction at bp_addr never executes.
   always_comb begin
      bp_match = bp_en && bp_armed_q && (pc == bp_addr);
      cpu_en   = ((state_q == ST_RUN) && !bp_match) || (state_q == ST_STEP);
   end

   always_comb begin
      state_d       = state_q;
      boot_cnt_d    = boot_cnt_q;
      bp_hit_d      = bp_hit_q;
      bp_armed_d    = bp_armed_q;
      cycle_count_d = cycle_count_q;
      if (cpu_en && (cycle_count_q != '1)) begin
         cycle_count_d = cycle_count_q + CYC_W'(1);
      end

      if (soft_rst_req) begin
         state_d       = ST_BOOT;
         boot_cnt_d    = BOOT_LOAD;
         bp_hit_d      = 1'b0;
         bp_armed_d    = 1'b1;
         cycle_count_d = '0;
      end else begin
         unique case (state_q)
            ST_BOOT: begin
               if (boot_cnt_q == '0) begin
                  state_d = START_HALTED ? ST_HALT : ST_RUN;
               end else begin
                  boot_cnt_d = boot_cnt_q - BC_W'(1);
               end
            end
            ST_HALT: begin
               // halt_req outranks step/run even though it is a no-op here
               if (!halt_req) begin
                  if (step_req) begin
                     state_d  = ST_STEP;
                     bp_hit_d = 1'b0;
                  end else if (run_req) begin
                     state_d    = ST_RUN;
                     bp_hit_d   = 1'b0;
                     bp_armed_d = 1'b0;
                  end
               end
            end
            ST_RUN: begin
               bp_armed_d = 1'b1;
               if (bp_match) begin
                  state_d  = ST_HALT;
                  bp_hit_d = 1'b1;
               end else if (halt_req) begin
                  state_d = ST_HALT;
               end
            end
            ST_STEP: begin
               state_d = ST_HALT;
            end
         endcase
      end

      cpu_rst_d = (state_d == ST_BOOT);
      halted_d  = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_BOOT;
         boot_cnt_q    <= BOOT_LOAD;
         bp_hit_q      <= 1'b0;
         bp_armed_q    <= 1'b1;
         cpu_rst_q     <= 1'b1;
         halted_q      <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         boot_cnt_q    <= boot_cnt_d;
         bp_hit_q      <= bp_hit_d;
         bp_armed_q    <= bp_armed_d;
         cpu_rst_q     <= cpu_rst_d;
         halted_q      <= halted_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign cpu_rst     = cpu_rst_q;
   assign halted      = halted_q;
   assign bp_hit      = bp_hit_q;
   assign state       = state_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_hack_exec_controller.sv
// Bench for hack_exec_controller: directed scenarios plus randomized button traffic,
// all outputs compared every cycle against a behavioural model.
module tb_hack_exec_controller;

   localparam int     BC   = 4;
   localparam bit     SH   = 1'b0;
   localparam int     CW   = 8;
   localparam longint MAXC = (64'd1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, soft_rst_req = 1'b0;
   logic          bp_en = 1'b0;
   logic [14:0]   bp_addr = '0, pc = '0;
   logic          cpu_rst, cpu_en, halted, bp_hit;
   logic [1:0]    state;
   logic [CW-1:0] cycle_count;

   hack_exec_controller #(.BOOT_CYCLES(BC), .START_HALTED(SH), .CYC_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .run_req(run_req), .halt_req(halt_req),
      .step_req(step_req), .soft_rst_req(soft_rst_req), .bp_en(bp_en),
      .bp_addr(bp_addr), .pc(pc), .cpu_rst(cpu_rst), .cpu_en(cpu_en),
      .halted(halted), .bp_hit(bp_hit), .state(state), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   bit chk_on = 1'b0;
   bit pc_auto = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Model: mode 0=BOOT 1=HALT 2=RUN 3=STEP; boot tracked as cycles elapsed.
   int     m_mode = 0;
   int     m_elapsed = 0;
   bit     m_hit = 1'b0, m_armed = 1'b1;
   longint m_cnt = 0;

   function automatic bit m_en();
      bit bp_block;
      bp_block = bp_en && m_armed && (pc == bp_addr);
      return (m_mode == 3) || (m_mode == 2 && !bp_block);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      bit en;
      if (!reset_n) begin
         m_mode <= 0; m_elapsed <= 0; m_hit <= 1'b0; m_armed <= 1'b1; m_cnt <= 0;
      end else begin
         en = m_en();
         if (soft_rst_req) begin
            m_mode <= 0; m_elapsed <= 0; m_hit <= 1'b0; m_armed <= 1'b1; m_cnt <= 0;
         end else begin
            if (en && m_cnt < MAXC) m_cnt <= m_cnt + 1;
            case (m_mode)
               0: if (m_elapsed == BC - 1) m_mode <= SH ? 1 : 2;
                  else m_elapsed <= m_elapsed + 1;
               1: if (!halt_req) begin
                     if (step_req) begin m_mode <= 3; m_hit <= 1'b0; end
                     else if (run_req) begin m_mode <= 2; m_hit <= 1'b0; m_armed <= 1'b0; end
                  end
               2: begin
                     m_armed <= 1'b1;
                     if (!en) begin m_mode <= 1; m_hit <= 1'b1; end
                     else if (halt_req) m_mode <= 1;
                  end
               default: m_mode <= 1;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("cpu_en", cpu_en, m_en());
         chk("cpu_rst", cpu_rst, m_mode == 0);
         chk("halted", halted, m_mode == 1);
         chk("bp_hit", bp_hit, m_hit);
         chk("state", state, m_mode);
         chk("cycle_count", cycle_count, m_cnt);
      end
   end

   // Returns 3 time units after the next rising edge with pulses cleared;
   // pc models the CPU advancing on each enabled edge.
   task automatic cycle();
      logic en;
      #1;
      en = cpu_en;
      @(posedge clk);
      #2;
      run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; soft_rst_req = 1'b0;
      if (pc_auto && en) pc = pc + 15'd1;
      #1;
   endtask

   initial begin
      int rst_hi, first_k, first_en, first_st, ens, n;

      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_state", state, 0);
      chk("rst_count", cycle_count, 0);
      chk("rst_halted", halted, 0);
      chk("rst_bp_hit", bp_hit, 0);
      chk_on = 1'b1;

      // boot timing
      reset_n = 1'b1;
      rst_hi = cpu_rst ? 1 : 0;
      first_k = -1; first_en = 0; first_st = 0;
      for (int i = 0; i < 8; i++) begin
         cycle();
         if (cpu_rst) rst_hi++;
         else if (first_k < 0) begin first_k = i; first_en = cpu_en; first_st = state; end
      end
      chk("boot_rst_cycles", rst_hi, 4);
      chk("boot_exit_edge", first_k, 3);
      chk("boot_exit_en", first_en, 1);
      chk("boot_exit_state", first_st, 2);

      // breakpoint
      halt_req = 1'b1; cycle();
      pc = 15'd0; bp_en = 1'b1; bp_addr = 15'd10; pc_auto = 1'b1;
      soft_rst_req = 1'b1; cycle();
      for (n = 0; n < 40 && !halted; n++) cycle();
      chk("bp_halted", halted, 1);
      chk("bp_pc", pc, 10);
      chk("bp_count", cycle_count, 10);
      chk("bp_hit_set", bp_hit, 1);
      run_req = 1'b1; cycle();
      chk("resume_bp_hit", bp_hit, 0);
      chk("resume_state", state, 2);
      cycle();
      chk("resume_pc", pc, 11);
      pc = 15'd3;
      for (n = 0; n < 40 && !halted; n++) cycle();
      chk("rehit_pc", pc, 10);
      chk("rehit_bp_hit", bp_hit, 1);
      chk("rehit_count", cycle_count, 18);

      // single step, breakpoint ignored while stepping
      ens = 0;
      for (int s = 0; s < 3; s++) begin
         step_req = 1'b1; cycle();
         if (cpu_en) ens++;
         chk("step_state", state, 3);
         repeat (4) begin cycle(); if (cpu_en) ens++; end
         chk("step_back_halt", state, 1);
      end
      chk("step_en_cycles", ens, 3);
      chk("step_count", cycle_count, 21);
      chk("step_bp_hit_clr", bp_hit, 0);

      // priority
      step_req = 1'b1; run_req = 1'b1; cycle();
      chk("prio_step_state", state, 3);
      cycle();
      chk("prio_step_halt", state, 1);
      halt_req = 1'b1; step_req = 1'b1; cycle();
      chk("prio_halt_over_step", state, 1);
      run_req = 1'b1; cycle();
      repeat (2) cycle();
      halt_req = 1'b1; soft_rst_req = 1'b1; cycle();
      chk("prio_soft_state", state, 0);
      chk("prio_soft_count", cycle_count, 0);
      chk("prio_soft_rst", cpu_rst, 1);

      // saturation
      bp_en = 1'b0;
      repeat (BC + 300) cycle();
      chk("sat_count", cycle_count, MAXC);
      chk("sat_state", state, 2);

      // randomized traffic
      pc = 15'd0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) == 0) soft_rst_req = 1'b1;
         if ($urandom_range(15) == 0) halt_req = 1'b1;
         if ($urandom_range(9) == 0) step_req = 1'b1;
         if ($urandom_range(7) == 0) run_req = 1'b1;
         if ($urandom_range(49) == 0) bp_en = ~bp_en;
         if ($urandom_range(49) == 0) bp_addr = 15'($urandom_range(15));
         cycle();
         if (pc > 15'd15) pc = 15'd0;
      end

      // async reset mid-RUN
      bp_en = 1'b0;
      soft_rst_req = 1'b1; cycle();
      for (n = 0; n < 20 && state != 2'd2; n++) cycle();
      repeat (3) cycle();
      chk("async_pre_en", cpu_en, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_cpu_en", cpu_en, 0);
      chk("async_cpu_rst", cpu_rst, 1);
      chk("async_state", state, 0);
      chk("async_count", cycle_count, 0);
      repeat (2) cycle();
      reset_n = 1'b1;
      repeat (8) cycle();
      chk_on = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
